writeback_queue: RTL and testbench
==================================

Name: writeback_queue

Overview:
- Writeback buffer directly upstream of the dual-write-port register file.
- Collects up to three results per cycle and replays them in program order through the two register-file write ports. The three sources are ALU lane 0, ALU lane 1 and the load-return lane.
- Also flags issue-stage read addresses that still have a queued write, so issue can stall instead of reading stale data.

Parameters:
- DATA_WIDTH, 32, result/register width
- NUM_REGISTERS_LOG2, 5, register address width
- DEPTH, 8, queue entries; power of two, >= 4
- DEPTH_LOG2, 3, log2(DEPTH)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- a0_valid / a0_addr / a0_data  in  1 / NUM_REGISTERS_LOG2 / DATA_WIDTH  ALU lane 0 result (oldest in program order)
- a1_valid / a1_addr / a1_data  in  1 / NUM_REGISTERS_LOG2 / DATA_WIDTH  ALU lane 1 result
- m_valid / m_addr / m_data  in  1 / NUM_REGISTERS_LOG2 / DATA_WIDTH  load-return result (youngest)
- in_ready  out  1  queue accepts this cycle's inputs
- write1 / write_address1 / write_data1  out  1 / NUM_REGISTERS_LOG2 / DATA_WIDTH  register-file write port 1 (older)
- write2 / write_address2 / write_data2  out  1 / NUM_REGISTERS_LOG2 / DATA_WIDTH  register-file write port 2 (younger)
- rd_addr0..rd_addr3  in  NUM_REGISTERS_LOG2 each  issue-stage read addresses
- pending_hit  out  4  bit k set when rd_addr k matches any occupied entry
- count  out  DEPTH_LOG2+1  occupancy
- stall_cycles  out  16  saturating count of cycles with any input valid while in_ready is low

Behaviour:
- State:
  - entry array of {addr, data}
  - head and tail pointers, each DEPTH_LOG2 bits, wrapping modulo DEPTH
  - count register
- Reset values (reset sampled at an edge): head=0, tail=0, count=0, stall_cycles=0. Entry contents are don't-care.
- While reset is high, write1, write2 and pending_hit are forced to 0 combinationally, and in_ready=0.
- Reset mid-operation drops all queued entries and stored data is never written.
- in_ready = (count <= DEPTH-3), computed from the registered count only. It does not credit a same-cycle dequeue. It is all-or-nothing.
- Enqueue when in_ready:
  - Valid inputs are packed in fixed order a0, a1, m into tail, tail+1, tail+2 (mod DEPTH), skipping invalid lanes.
  - tail advances by the number of valid inputs.
- When in_ready=0, producers hold their valid/addr/data stable. Nothing is accepted, and stall_cycles increments if any valid is high, saturating at 0xFFFF.
- Dequeue:
  - write1 = (count>=1), with address and data from entry[head].
  - write2 = (count>=2), with address and data from entry[head+1].
  - The register file always accepts, so shown entries retire at the edge: head advances by write1+write2.
- count_next = count + enqueued - dequeued. Enqueue and dequeue in the same cycle are legal. count never exceeds DEPTH.
- Latency: an entry enqueued at edge N appears on a write port in cycle N+1 at the earliest. It is never presented in the cycle of its own acceptance.
- Same-address ordering: the older entry always goes on port 1. The register file applies port 2 after port 1, so the younger value wins.
- Pointer wrap: entries straddling index DEPTH-1 to 0 are read and written correctly.
- pending_hit[k]:
  - Set when rd_addr k equals the addr of any occupied entry (index in [head, head+count) mod DEPTH).
  - Entries currently driven on write1/write2 count as occupied, which is conservative.
  - This cycle's incoming inputs are excluded.
- No bypass of data to readers; issue logic stalls on pending_hit.

Decomposition:
- Shared package/header:
  - DATA_WIDTH and NUM_REGISTERS_LOG2 defines, used by the register file as well.
  - A writeback-entry struct {addr, data}.
  - WB_QUEUE_DEPTH constant.
- One natural sub-module: wbq_hazard_cam, the combinational 4-port address compare over DEPTH entries, taking an occupancy mask. Everything else stays in writeback_queue.

Test Plan:
- Single write: a0_valid=1, addr=3, data=0xDEAD at edge 0.
  - Cycle 1: write1=1, write_address1=3, write_data1=0xDEAD, write2=0.
  - Cycle 2: count=0.
- Triple issue: a0 (r1=0x11), a1 (r2=0x22), m (r3=0x33) in one cycle.
  - Next cycle: port1=r1/0x11, port2=r2/0x22.
  - Following cycle: port1=r3/0x33, write2=0.
- Sparse pack: only a1 (r4=0x44) and m (r5=0x55) valid. Both land in consecutive slots, so the next cycle shows port1=r4, port2=r5.
- WAW: a0 r7=1, a1 r7=2 in the same cycle. Next cycle: port1 data=1, port2 data=2; the register file ends with r7=2.
- Fill and backpressure:
  - Triple inputs every cycle reach count=6 and in_ready=0.
  - Inputs held 3 cycles give stall_cycles=3.
  - The drain re-enables acceptance. Output order across wrap at index 7→0 matches input order exactly.
- Hazard and reset:
  - With r9 queued, rd_addr2=9 gives pending_hit=4'b0100.
  - Asserting reset for one cycle with count=5 gives count=0, no further writes, and pending_hit=0.

Source files
------------

// File: rtl/writeback_queue_pkg.sv
// Shared definitions for the writeback path.
//   RF_DATA_WIDTH / RF_NUM_REGISTERS_LOG2 : register-file geometry (also used by the register file)
//   WB_QUEUE_DEPTH                        : writeback queue entries
//   wb_entry_t                            : one queued result {addr, data}
//   count_valid()                         : number of asserted lanes out of three
package writeback_queue_pkg;

  localparam int unsigned RF_DATA_WIDTH         = 32;
  localparam int unsigned RF_NUM_REGISTERS_LOG2 = 5;
  localparam int unsigned WB_QUEUE_DEPTH        = 8;
  localparam int unsigned WB_NUM_READ_PORTS     = 4;

  typedef struct packed {
    logic [RF_NUM_REGISTERS_LOG2-1:0] addr;
    logic [RF_DATA_WIDTH-1:0]         data;
  } wb_entry_t;

  function automatic logic [1:0] count_valid(input logic v0, input logic v1, input logic v2);
    return {1'b0, v0} + {1'b0, v1} + {1'b0, v2};
  endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Result lanes into the writeback queue and register-file write ports out of it.
//   a0_*, a1_*, m_* : ALU lane 0 (oldest), ALU lane 1, load return (youngest)
//   in_ready        : queue accepts this cycle's lanes
//   write1/2_*      : register-file write ports, port 1 older than port 2
// master = producer/register-file side, slave = the queue.
interface writeback_queue_if
  import writeback_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = RF_DATA_WIDTH,
  parameter int unsigned NUM_REGISTERS_LOG2 = RF_NUM_REGISTERS_LOG2
) ();

  logic                          a0_valid;
  logic [NUM_REGISTERS_LOG2-1:0] a0_addr;
  logic [DATA_WIDTH-1:0]         a0_data;
  logic                          a1_valid;
  logic [NUM_REGISTERS_LOG2-1:0] a1_addr;
  logic [DATA_WIDTH-1:0]         a1_data;
  logic                          m_valid;
  logic [NUM_REGISTERS_LOG2-1:0] m_addr;
  logic [DATA_WIDTH-1:0]         m_data;
  logic                          in_ready;
  logic                          write1;
  logic [NUM_REGISTERS_LOG2-1:0] write_address1;
  logic [DATA_WIDTH-1:0]         write_data1;
  logic                          write2;
  logic [NUM_REGISTERS_LOG2-1:0] write_address2;
  logic [DATA_WIDTH-1:0]         write_data2;

  modport master (
    output a0_valid, a0_addr, a0_data,
    output a1_valid, a1_addr, a1_data,
    output m_valid, m_addr, m_data,
    input  in_ready,
    input  write1, write_address1, write_data1,
    input  write2, write_address2, write_data2
  );

  modport slave (
    input  a0_valid, a0_addr, a0_data,
    input  a1_valid, a1_addr, a1_data,
    input  m_valid, m_addr, m_data,
    output in_ready,
    output write1, write_address1, write_data1,
    output write2, write_address2, write_data2
  );

endinterface

// File: rtl/wbq_hazard_cam.sv
// Combinational read-address compare against every queue entry.
//   entry_addr : register address held in each entry
//   occupied   : entries currently holding a not-yet-retired write
//   rd_addr    : issue-stage read addresses
//   hit        : bit k set when rd_addr[k] matches any occupied entry
module wbq_hazard_cam
  import writeback_queue_pkg::*;
#(
  parameter int unsigned NUM_REGISTERS_LOG2 = RF_NUM_REGISTERS_LOG2,
  parameter int unsigned DEPTH              = WB_QUEUE_DEPTH,
  parameter int unsigned NUM_PORTS          = WB_NUM_READ_PORTS
) (
  input  logic [NUM_REGISTERS_LOG2-1:0] entry_addr [DEPTH],
  input  logic [DEPTH-1:0]              occupied,
  input  logic [NUM_REGISTERS_LOG2-1:0] rd_addr    [NUM_PORTS],
  output logic [NUM_PORTS-1:0]          hit
);

  always_comb begin
    hit = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (occupied[i] && (entry_addr[i] == rd_addr[k])) hit[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Writeback buffer in front of the dual-write-port register file.
// Accepts up to three results per cycle (a0, a1, m in program order), retires
// up to two per cycle in order on write1 (older) / write2 (younger), and flags
// issue reads whose register still has a queued write.
//   clk, reset        : clock, synchronous active-high reset
//   wb                : result lanes, in_ready, register-file write ports
//   rd_addr0..3       : issue-stage read addresses
//   pending_hit       : per-read-port hazard flags
//   count             : occupancy
//   stall_cycles      : saturating count of cycles with a valid lane refused
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = RF_DATA_WIDTH,
  parameter int unsigned NUM_REGISTERS_LOG2 = RF_NUM_REGISTERS_LOG2,
  parameter int unsigned DEPTH              = WB_QUEUE_DEPTH,
  parameter int unsigned DEPTH_LOG2         = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  writeback_queue_if.slave              wb,
  input  logic [NUM_REGISTERS_LOG2-1:0] rd_addr0,
  input  logic [NUM_REGISTERS_LOG2-1:0] rd_addr1,
  input  logic [NUM_REGISTERS_LOG2-1:0] rd_addr2,
  input  logic [NUM_REGISTERS_LOG2-1:0] rd_addr3,
  output logic [3:0]                    pending_hit,
  output logic [DEPTH_LOG2:0]           count,
  output logic [15:0]                   stall_cycles
);

  typedef struct packed {
    logic [NUM_REGISTERS_LOG2-1:0] addr;
    logic [DATA_WIDTH-1:0]         data;
  } entry_t;

  entry_t                        entries [DEPTH];
  logic [DEPTH_LOG2-1:0]         head;
  logic [DEPTH_LOG2-1:0]         tail;
  logic [DEPTH_LOG2-1:0]         head_p1;
  logic [DEPTH_LOG2-1:0]         slot_a1;
  logic [DEPTH_LOG2-1:0]         slot_m;
  logic [DEPTH_LOG2-1:0]         offset;
  logic                          accept;
  logic                          any_valid;
  logic [1:0]                    n_enq;
  logic [1:0]                    n_deq;
  logic [DEPTH-1:0]              occupied;
  logic [NUM_REGISTERS_LOG2-1:0] entry_addr [DEPTH];
  logic [NUM_REGISTERS_LOG2-1:0] rd_addr    [4];

  always_comb begin
    any_valid = wb.a0_valid | wb.a1_valid | wb.m_valid;
    // Decided from the registered count alone so producers never see a
    // combinational path from this cycle's dequeue.
    accept    = (count <= (DEPTH_LOG2+1)'(DEPTH - 3));
    n_enq     = accept ? count_valid(wb.a0_valid, wb.a1_valid, wb.m_valid) : 2'd0;
    n_deq     = (count >= (DEPTH_LOG2+1)'(2)) ? 2'd2 :
                (count != '0)                 ? 2'd1 : 2'd0;
    // Invalid lanes are skipped, so later lanes pack down onto earlier slots.
    slot_a1   = tail + DEPTH_LOG2'(wb.a0_valid);
    slot_m    = tail + DEPTH_LOG2'(count_valid(wb.a0_valid, wb.a1_valid, 1'b0));
    head_p1   = head + DEPTH_LOG2'(1);

    wb.in_ready       = accept & ~reset;
    wb.write1         = (count != '0) & ~reset;
    wb.write_address1 = entries[head].addr;
    wb.write_data1    = entries[head].data;
    wb.write2         = (count >= (DEPTH_LOG2+1)'(2)) & ~reset;
    wb.write_address2 = entries[head_p1].addr;
    wb.write_data2    = entries[head_p1].data;

    // Entries being retired this cycle still count as occupied; this
    // cycle's incoming lanes are not yet in the array and never hit.
    offset   = '0;
    occupied = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset        = DEPTH_LOG2'(i) - head;
      occupied[i]   = ({1'b0, offset} < count) & ~reset;
      entry_addr[i] = entries[i].addr;
    end

    rd_addr[0] = rd_addr0;
    rd_addr[1] = rd_addr1;
    rd_addr[2] = rd_addr2;
    rd_addr[3] = rd_addr3;
  end

  wbq_hazard_cam #(
    .NUM_REGISTERS_LOG2 (NUM_REGISTERS_LOG2),
    .DEPTH              (DEPTH),
    .NUM_PORTS          (4)
  ) u_hazard_cam (
    .entry_addr (entry_addr),
    .occupied   (occupied),
    .rd_addr    (rd_addr),
    .hit        (pending_hit)
  );

  // Entry storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      if (wb.a0_valid) entries[tail]    <= '{addr: wb.a0_addr, data: wb.a0_data};
      if (wb.a1_valid) entries[slot_a1] <= '{addr: wb.a1_addr, data: wb.a1_data};
      if (wb.m_valid)  entries[slot_m]  <= '{addr: wb.m_addr,  data: wb.m_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      stall_cycles <= '0;
    end else begin
      tail  <= tail + DEPTH_LOG2'(n_enq);
      head  <= head + DEPTH_LOG2'(n_deq);
      count <= count + (DEPTH_LOG2+1)'(n_enq) - (DEPTH_LOG2+1)'(n_deq);
      if (!accept && any_valid && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr0, rd_addr1, rd_addr2, rd_addr3;
  logic [3:0]  pending_hit;
  logic [3:0]  count;
  logic [15:0] stall_cycles;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  writeback_queue_if wb_bus ();

  writeback_queue dut (
    .clk          (clk),
    .reset        (reset),
    .wb           (wb_bus),
    .rd_addr0     (rd_addr0),
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .rd_addr3     (rd_addr3),
    .pending_hit  (pending_hit),
    .count        (count),
    .stall_cycles (stall_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic set_lanes(input logic v0, input logic [4:0] ad0, input logic [31:0] d0,
                           input logic v1, input logic [4:0] ad1, input logic [31:0] d1,
                           input logic vm, input logic [4:0] adm, input logic [31:0] dm);
    wb_bus.a0_valid = v0; wb_bus.a0_addr = ad0; wb_bus.a0_data = d0;
    wb_bus.a1_valid = v1; wb_bus.a1_addr = ad1; wb_bus.a1_data = d1;
    wb_bus.m_valid  = vm; wb_bus.m_addr  = adm; wb_bus.m_data  = dm;
  endtask

  task automatic clear_lanes();
    set_lanes(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference queue for the fill/drain phase.
  wb_entry_t   exp_q[$];
  wb_entry_t   ent;
  int unsigned seq;
  logic        exp_ready;
  logic [15:0] m_stall;

  task automatic chk_ports(input string tag);
    chk({tag, "_w1"}, 64'(wb_bus.write1), 64'(exp_q.size() >= 1));
    chk({tag, "_w2"}, 64'(wb_bus.write2), 64'(exp_q.size() >= 2));
    if (exp_q.size() >= 1) begin
      chk({tag, "_a1"}, 64'(wb_bus.write_address1), 64'(exp_q[0].addr));
      chk({tag, "_d1"}, 64'(wb_bus.write_data1),    64'(exp_q[0].data));
    end
    if (exp_q.size() >= 2) begin
      chk({tag, "_a2"}, 64'(wb_bus.write_address2), 64'(exp_q[1].addr));
      chk({tag, "_d2"}, 64'(wb_bus.write_data2),    64'(exp_q[1].data));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    clear_lanes();
    rd_addr0 = 5'd31; rd_addr1 = 5'd31; rd_addr2 = 5'd31; rd_addr3 = 5'd31;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 64'(wb_bus.in_ready), 64'(0));
    chk("rst_write1",   64'(wb_bus.write1),   64'(0));
    chk("rst_write2",   64'(wb_bus.write2),   64'(0));
    chk("rst_pending",  64'(pending_hit),     64'(0));
    chk("rst_count",    64'(count),           64'(0));
    chk("rst_stall",    64'(stall_cycles),    64'(0));
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(wb_bus.in_ready), 64'(1));
    chk("idle_write1",   64'(wb_bus.write1),   64'(0));
    step();

    // Single write: never presented in its own acceptance cycle
    set_lanes(1'b1, 5'd3, 32'hDEAD, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("single_same_cycle_w1", 64'(wb_bus.write1), 64'(0));
    step();
    clear_lanes();
    @(negedge clk);
    chk("single_w1",    64'(wb_bus.write1),         64'(1));
    chk("single_a1",    64'(wb_bus.write_address1), 64'(3));
    chk("single_d1",    64'(wb_bus.write_data1),    64'(32'hDEAD));
    chk("single_w2",    64'(wb_bus.write2),         64'(0));
    chk("single_count", 64'(count),                 64'(1));
    step();
    @(negedge clk);
    chk("single_drained", 64'(count),         64'(0));
    chk("single_w1_off",  64'(wb_bus.write1), 64'(0));
    step();

    // Triple issue
    set_lanes(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 32'h33);
    step();
    clear_lanes();
    @(negedge clk);
    chk("triple_count", 64'(count),                 64'(3));
    chk("triple_a1",    64'(wb_bus.write_address1), 64'(1));
    chk("triple_d1",    64'(wb_bus.write_data1),    64'(32'h11));
    chk("triple_w2",    64'(wb_bus.write2),         64'(1));
    chk("triple_a2",    64'(wb_bus.write_address2), 64'(2));
    chk("triple_d2",    64'(wb_bus.write_data2),    64'(32'h22));
    step();
    @(negedge clk);
    chk("triple2_count", 64'(count),                 64'(1));
    chk("triple2_a1",    64'(wb_bus.write_address1), 64'(3));
    chk("triple2_d1",    64'(wb_bus.write_data1),    64'(32'h33));
    chk("triple2_w2",    64'(wb_bus.write2),         64'(0));
    step();

    // Sparse pack: a1 and m only
    set_lanes(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd5, 32'h55);
    step();
    clear_lanes();
    @(negedge clk);
    chk("sparse_count", 64'(count),                 64'(2));
    chk("sparse_a1",    64'(wb_bus.write_address1), 64'(4));
    chk("sparse_d1",    64'(wb_bus.write_data1),    64'(32'h44));
    chk("sparse_a2",    64'(wb_bus.write_address2), 64'(5));
    chk("sparse_d2",    64'(wb_bus.write_data2),    64'(32'h55));
    step();

    // WAW: older value on port 1, younger on port 2
    set_lanes(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, 1'b0, 5'd0, 32'd0);
    step();
    clear_lanes();
    @(negedge clk);
    chk("waw_a1", 64'(wb_bus.write_address1), 64'(7));
    chk("waw_d1", 64'(wb_bus.write_data1),    64'(1));
    chk("waw_a2", 64'(wb_bus.write_address2), 64'(7));
    chk("waw_d2", 64'(wb_bus.write_data2),    64'(2));
    step();

    // Hazard: incoming lane excluded, queued entry flagged
    rd_addr0 = 5'd10;
    rd_addr2 = 5'd9;
    set_lanes(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("hazard_incoming", 64'(pending_hit), 64'(0));
    step();
    clear_lanes();
    @(negedge clk);
    chk("hazard_queued", 64'(pending_hit), 64'(4'b0100));
    step();
    @(negedge clk);
    chk("hazard_retired", 64'(pending_hit), 64'(0));
    chk("hazard_count",   64'(count),       64'(0));
    rd_addr0 = 5'd31;
    rd_addr2 = 5'd31;
    step();

    // Fill and backpressure, triples every cycle; order checked across wrap
    seq     = 0;
    m_stall = '0;
    for (int c = 0; c < 12; c++) begin
      set_lanes(1'b1, 5'(seq),     32'h1000 + seq,
                1'b1, 5'(seq + 1), 32'h1000 + seq + 1,
                1'b1, 5'(seq + 2), 32'h1000 + seq + 2);
      @(negedge clk);
      exp_ready = (exp_q.size() <= 5);
      chk("fill_in_ready", 64'(wb_bus.in_ready), 64'(exp_ready));
      chk("fill_count",    64'(count),           64'(exp_q.size()));
      if (c == 4) begin
        chk("fill_full_count",    64'(count),           64'(6));
        chk("fill_full_in_ready", 64'(wb_bus.in_ready), 64'(0));
      end
      chk_ports("fill");
      for (int d = 0; d < 2; d++) if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_ready) begin
        for (int j = 0; j < 3; j++) begin
          ent.addr = 5'(seq);
          ent.data = 32'h1000 + seq;
          exp_q.push_back(ent);
          seq++;
        end
      end else begin
        m_stall++;
      end
      step();
    end
    clear_lanes();
    @(negedge clk);
    chk("fill_stall_cycles", 64'(stall_cycles), 64'(3));
    chk("fill_stall_model",  64'(stall_cycles), 64'(m_stall));
    chk("fill_end_count",    64'(count),        64'(5));
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      chk("drain_count", 64'(count), 64'(exp_q.size()));
      chk_ports("drain");
      for (int d = 0; d < 2; d++) if (exp_q.size() > 0) void'(exp_q.pop_front());
      step();
    end

    // Reset mid-operation with five entries queued
    rd_addr0 = 5'd26;
    set_lanes(1'b1, 5'd20, 32'd20, 1'b1, 5'd21, 32'd21, 1'b1, 5'd22, 32'd22);
    step();
    set_lanes(1'b1, 5'd23, 32'd23, 1'b1, 5'd24, 32'd24, 1'b1, 5'd25, 32'd25);
    step();
    set_lanes(1'b1, 5'd26, 32'd26, 1'b1, 5'd27, 32'd27, 1'b1, 5'd28, 32'd28);
    step();
    clear_lanes();
    @(negedge clk);
    chk("pre_reset_count",   64'(count),       64'(5));
    chk("pre_reset_pending", 64'(pending_hit), 64'(4'b0001));
    reset = 1'b1;
    #1;
    chk("in_reset_w1",       64'(wb_bus.write1),   64'(0));
    chk("in_reset_w2",       64'(wb_bus.write2),   64'(0));
    chk("in_reset_pending",  64'(pending_hit),     64'(0));
    chk("in_reset_in_ready", 64'(wb_bus.in_ready), 64'(0));
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_count",   64'(count),           64'(0));
    chk("post_reset_w1",      64'(wb_bus.write1),   64'(0));
    chk("post_reset_w2",      64'(wb_bus.write2),   64'(0));
    chk("post_reset_pending", 64'(pending_hit),     64'(0));
    chk("post_reset_ready",   64'(wb_bus.in_ready), 64'(1));
    chk("post_reset_stall",   64'(stall_cycles),    64'(0));
    step();
    @(negedge clk);
    chk("post_reset_w1_later", 64'(wb_bus.write1), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
